// File: rtl/bus_master_if_pkg.sv
// Shared encodings for the CPU-side bus master port.
package bus_master_if_pkg;

    localparam int unsigned TransWidth = 2;

    typedef enum logic [TransWidth-1:0] {
        IDLE   = 2'b00,
        NONSEQ = 2'b10
    } pkg_trans;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } pkg_resp;

    typedef enum logic {
        FALSE = 1'b0,
        TRUE  = 1'b1
    } pkg_bool;

endpackage

// File: rtl/bus_master_if_d_ff.sv
// Generic register with synchronous active-high reset to a parameterised value.
module bus_master_if_d_ff #(
    parameter int unsigned     Width    = 1,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_o <= ResetVal;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/bus_master_if.sv
// CPU req/gnt handshake to pipelined bus transfers: NONSEQ address phase,
// ready-stalled data phase, two-cycle error response and saturating error count.
//
// state  | meaning
// StIdle | no data phase outstanding
// StData | data phase outstanding
// StErr  | first ERROR cycle seen, waiting for the closing ready
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned DWidth   = 32,
    parameter int unsigned CntWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [DWidth-1:0]     addr_i,
    input  logic [DWidth-1:0]     wdata_i,
    output logic                  gnt_o,
    output logic                  rsp_valid_o,
    output logic [DWidth-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [TransWidth-1:0] trans_o,
    output logic                  write_o,
    output logic [DWidth-1:0]     addr_o,
    output logic [DWidth-1:0]     wdata_o,
    input  logic                  ready_i,
    input  logic                  resp_i,
    input  logic [DWidth-1:0]     rdata_i,
    output logic [CntWidth-1:0]   err_cnt_o
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StData = 2'd1,
        StErr  = 2'd2
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    state_e              state_q, state_d;
    logic [1:0]          state_raw_q;
    logic                wr_q, wr_d;
    logic [DWidth-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DWidth-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
    logic                gnt;
    logic                err_done;

    assign state_q = state_e'(state_raw_q);

    always_comb begin
        gnt         = req_i & ready_i & (state_q != StErr)
                      & ~((state_q == StData) & (resp_i == ERROR) & ~ready_i);
        state_d     = state_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        err_done    = 1'b0;

        if (gnt) begin
            wr_d    = we_i;
            wdata_d = wdata_i;
        end

        case (state_q)
            StIdle: begin
                if (gnt) state_d = StData;
            end
            StData: begin
                if (ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? '0 : rdata_i;
                    rsp_err_d   = (resp_i == ERROR);
                    err_done    = (resp_i == ERROR);
                    state_d     = gnt ? StData : StIdle;
                end else if (resp_i == ERROR) begin
                    state_d = StErr;
                end
            end
            StErr: begin
                if (ready_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    err_done    = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counter sticks at all-ones instead of wrapping
        err_cnt_d = (err_done && (err_cnt_q != CntMax)) ? err_cnt_q + CntWidth'(1) : err_cnt_q;
    end

    bus_master_if_d_ff #(.Width(2), .ResetVal(2'd0)) u_state_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(state_d), .q_o(state_raw_q)
    );
    bus_master_if_d_ff #(.Width(1), .ResetVal(1'b0)) u_wr_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(wr_d), .q_o(wr_q)
    );
    bus_master_if_d_ff #(.Width(DWidth), .ResetVal('0)) u_wdata_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(wdata_d), .q_o(wdata_q)
    );
    bus_master_if_d_ff #(.Width(1), .ResetVal(1'b0)) u_rsp_valid_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(rsp_valid_d), .q_o(rsp_valid_q)
    );
    bus_master_if_d_ff #(.Width(DWidth), .ResetVal('0)) u_rsp_rdata_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(rsp_rdata_d), .q_o(rsp_rdata_q)
    );
    bus_master_if_d_ff #(.Width(1), .ResetVal(1'b0)) u_rsp_err_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(rsp_err_d), .q_o(rsp_err_q)
    );
    bus_master_if_d_ff #(.Width(CntWidth), .ResetVal('0)) u_err_cnt_q (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(err_cnt_d), .q_o(err_cnt_q)
    );

    assign gnt_o       = gnt;
    assign trans_o     = gnt ? NONSEQ : IDLE;
    assign write_o     = gnt & we_i;
    assign addr_o      = addr_i;
    assign wdata_o     = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Directed stimulus for bus_master_if with a response scoreboard checked by a monitor.
module tb_bus_master_if;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst, req, we, ready, resp;
    logic [DW-1:0] addr, wdata, rdata;
    logic          gnt_o, rsp_valid_o, rsp_err_o, write_o;
    logic [DW-1:0] rsp_rdata_o, addr_o, wdata_o;
    logic [1:0]    trans_o;
    logic [CW-1:0] err_cnt_o;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int unsigned   cyc;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    bus_master_if #(.DWidth(DW), .CntWidth(CW)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .trans_o(trans_o),
        .write_o(write_o), .addr_o(addr_o), .wdata_o(wdata_o), .ready_i(ready),
        .resp_i(resp), .rdata_i(rdata), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void push(int unsigned c, logic e, logic [DW-1:0] d);
        exp_t x;
        x.cyc = c; x.err = e; x.rdata = d;
        sb.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (rsp_valid_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp at cycle %0d: got rsp_valid_o=1 expected no response", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
                chk("rsp_rdata", rsp_rdata_o, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req = 0; we = 0; addr = '0; wdata = '0;
        ready = 1; resp = 0; rdata = '0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            tick();
            idle_in();
        end
    endtask

    task automatic do_reset();
        tick();
        idle_in();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst_trans", {30'd0, trans_o}, 32'd0);
        chk("rst_gnt", {31'd0, gnt_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_err_cnt", {30'd0, err_cnt_o}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        int unsigned k_exp;
        rst = 1;
        idle_in();

        // Reset state
        do_reset();

        // Single read, zero wait
        tick(); req = 1; we = 0; addr = 32'h100;
        n = cyc; push(n + 2, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_gnt", {31'd0, gnt_o}, 32'd1);
        chk("t1_trans", {30'd0, trans_o}, 32'd2);
        chk("t1_addr", addr_o, 32'h100);
        chk("t1_write", {31'd0, write_o}, 32'd0);
        tick(); req = 0; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t1_trans_dp", {30'd0, trans_o}, 32'd0);
        idle(3);

        // Write with two wait states
        tick(); req = 1; we = 1; addr = 32'h40; wdata = 32'h12345678;
        n = cyc; push(n + 4, 1'b0, 32'h0);
        @(negedge clk);
        chk("t2_gnt", {31'd0, gnt_o}, 32'd1);
        chk("t2_write", {31'd0, write_o}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(); req = 1; we = 0; addr = 32'h80; wdata = 32'hAAAAAAAA; ready = 0;
            @(negedge clk);
            chk("t2_wait_gnt", {31'd0, gnt_o}, 32'd0);
            chk("t2_wait_trans", {30'd0, trans_o}, 32'd0);
            chk("t2_wait_wdata", wdata_o, 32'h12345678);
        end
        tick(); req = 0; ready = 1; rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("t2_last_wdata", wdata_o, 32'h12345678);
        idle(3);

        // Back-to-back reads
        for (int k = 0; k < 4; k++) begin
            tick(); req = 1; we = 0; addr = 32'(k * 4);
            rdata = (k == 0) ? 32'h0 : 32'hA0000000 + 32'(k - 1);
            push(cyc + 2, 1'b0, 32'hA0000000 + 32'(k));
            @(negedge clk);
            chk("t3_gnt", {31'd0, gnt_o}, 32'd1);
            chk("t3_addr", addr_o, 32'(k * 4));
        end
        tick(); req = 0; rdata = 32'hA0000003;
        @(negedge clk);
        chk("t3_gnt_end", {31'd0, gnt_o}, 32'd0);
        idle(3);

        // Two-cycle error with a pending request
        do_reset();
        tick(); req = 1; we = 0; addr = 32'h200;
        n = cyc; push(n + 3, 1'b1, 32'h0);
        @(negedge clk);
        chk("t4_gnt", {31'd0, gnt_o}, 32'd1);
        tick(); req = 1; addr = 32'h300; ready = 0; resp = 1;
        @(negedge clk);
        chk("t4_err1_gnt", {31'd0, gnt_o}, 32'd0);
        chk("t4_err1_trans", {30'd0, trans_o}, 32'd0);
        tick(); ready = 1; resp = 1;
        @(negedge clk);
        chk("t4_err2_gnt", {31'd0, gnt_o}, 32'd0);
        chk("t4_err2_trans", {30'd0, trans_o}, 32'd0);
        tick(); ready = 1; resp = 0;
        push(cyc + 2, 1'b0, 32'h55);
        @(negedge clk);
        chk("t4_regnt", {31'd0, gnt_o}, 32'd1);
        chk("t4_regnt_trans", {30'd0, trans_o}, 32'd2);
        chk("t4_regnt_addr", addr_o, 32'h300);
        chk("t4_err_cnt", {30'd0, err_cnt_o}, 32'd1);
        tick(); req = 0; rdata = 32'h55;
        @(negedge clk);
        chk("t4_err_cnt_hold", {30'd0, err_cnt_o}, 32'd1);
        idle(3);

        // Reset during a stalled data phase
        do_reset();
        tick(); req = 1; we = 0; addr = 32'h500;
        @(negedge clk);
        chk("t5_gnt", {31'd0, gnt_o}, 32'd1);
        tick(); req = 0; ready = 0; rst = 1;
        tick(); rst = 0; ready = 1; rdata = 32'h77;
        @(negedge clk);
        chk("t5_trans", {30'd0, trans_o}, 32'd0);
        chk("t5_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("t5_err_cnt", {30'd0, err_cnt_o}, 32'd0);
        idle(4);

        // Saturation: alternate single-cycle and two-cycle errors
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            tick(); req = 1; we = 0; addr = 32'(k * 16);
            n = cyc;
            @(negedge clk);
            chk("t6_gnt", {31'd0, gnt_o}, 32'd1);
            if (k % 2 == 0) begin
                push(n + 3, 1'b1, 32'h0);
                tick(); req = 0; ready = 0; resp = 1;
                tick(); ready = 1; resp = 1;
            end else begin
                push(n + 2, 1'b1, 32'h0);
                tick(); req = 0; ready = 1; resp = 1; rdata = 32'h0;
            end
            tick(); resp = 0;
            k_exp = (k > 3) ? 3 : k;
            @(negedge clk);
            chk("t6_err_cnt", {30'd0, err_cnt_o}, k_exp);
        end
        idle(3);

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Bus-side master port for the CPU load/store unit, placed directly upstream of the memory-slave interface on the shared bus.
- Converts a simple req/gnt/rsp handshake from the CPU into pipelined bus transfers: an address phase with NONSEQ, then a data phase that waits on the bus ready.
- Returns read data or a completion acknowledgement to the CPU, implements the two-cycle error response, and counts errors.

Parameters:
DWidth, 32, address and data width
CntWidth, 8, width of the saturating error counter

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock; reset is synchronous and active-high
req_i  input  1  CPU request valid
we_i  input  1  CPU request is a write
addr_i  input  DWidth  CPU request address
wdata_i  input  DWidth  CPU write data, sampled at grant
gnt_o  output  1  request accepted this cycle
rsp_valid_o  output  1  one-cycle pulse when a transfer completes
rsp_rdata_o  output  DWidth  read data, valid with rsp_valid_o
rsp_err_o  output  1  completed transfer returned ERROR
trans_o  output  2  bus transfer type (IDLE/NONSEQ, pkg_trans encoding)
write_o  output  1  bus write
addr_o  output  DWidth  bus address
wdata_o  output  DWidth  bus write data, driven during the data phase
ready_i  input  1  bus ready (global HREADY-style signal)
resp_i  input  1  bus response: 0 = OKAY, 1 = ERROR
rdata_i  input  DWidth  bus read data
err_cnt_o  output  CntWidth  saturating count of ERROR completions

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - FSM goes to StIdle; wr_q, wdata_q, rsp_* registers and err_cnt are cleared.
  - After the edge: trans_o=IDLE, gnt_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, err_cnt_o=0.
  - A data phase in flight is abandoned and produces no response.
- FSM states:
  - StIdle: no data phase outstanding.
  - StData: data phase outstanding.
  - StErr: first ERROR cycle has been seen.
- Grant: gnt_o = req_i & ready_i & (state != StErr) & ~(state==StData & resp_i & ~ready_i).
  - Mealy and combinational, so grant is possible in StIdle, and in StData during the cycle the current data phase completes (back-to-back).
- Address phase (combinational):
  - When gnt_o=1: trans_o=NONSEQ, addr_o=addr_i, write_o=we_i.
  - Otherwise: trans_o=IDLE, write_o=0, addr_o=addr_i.
- On grant at edge N:
  - wr_q<=we_i and wdata_q<=wdata_i.
  - Next state is StData; the data phase starts at N+1.
  - wdata_o=wdata_q at all times.
- StData completion (ready_i=1 at the edge):
  - Registered response pulse on the next cycle: rsp_valid_o=1, rsp_rdata_o = wr_q ? 0 : rdata_i, rsp_err_o=resp_i.
  - Next state: StData if a new grant occurred in the same cycle, else StIdle.
- StData with ready_i=0 and resp_i=0: wait state; hold StData, no grant.
- StData with ready_i=0 and resp_i=1: first error cycle.
  - gnt_o=0, trans_o=IDLE; go to StErr.
- StErr:
  - trans_o=IDLE, gnt_o=0.
  - When ready_i=1: registered response with rsp_err_o=1; err_cnt increments (saturates at 2^CntWidth-1); go to StIdle.
  - While ready_i=0: hold StErr (protocol violation tolerated).
- A single-cycle error (resp_i=1 with ready_i=1 in StData) is accepted as an error completion and also increments err_cnt.
- Latency:
  - Grant at cycle N; zero-wait data phase at N+1; rsp_valid_o at N+2.
  - Each slave wait state adds one cycle.
  - Sustained throughput is one transfer per cycle.
- At most one data phase is outstanding; no SEQ/burst transfers are generated.

Decomposition:
- pkg_trans: transfer-type encoding (IDLE, NONSEQ).
- pkg_resp: OKAY/ERROR.
- pkg_bool: TRUE/FALSE.
- The state typedef (StIdle, StData, StErr) stays local to the module.
- All state and data registers are instantiated through the existing D_FF register sub-module, one instance per register, with synchronous-reset variants.
- The saturating counter stays inline; no other sub-module.

Test Plan:
1. Single read, zero wait: req_i=1, we_i=0, addr_i=0x100 at N, rdata_i=0xDEADBEEF at N+1 -> gnt_o=1 and trans_o=NONSEQ at N; rsp_valid_o=1, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0 at N+2.
2. Write with 2 wait states: we_i=1, addr_i=0x40, wdata_i=0x12345678; ready_i=0 at N+1 and N+2 -> wdata_o=0x12345678 held through N+3; rsp_valid_o at N+4; gnt_o stays 0 during the waits.
3. Back-to-back: four reads to 0x0, 0x4, 0x8, 0xC with req_i held high -> gnt_o high four consecutive cycles; four rsp_valid_o pulses on consecutive cycles, in order.
4. Two-cycle error: slave drives resp_i=1/ready_i=0, then resp_i=1/ready_i=1, while req_i is pending -> trans_o=IDLE and gnt_o=0 in both cycles; rsp_err_o=1; err_cnt_o=1; the pending request is granted on the following cycle.
5. Reset mid-transfer: assert rst_i during StData with ready_i=0 -> next cycle trans_o=IDLE, no rsp_valid_o ever produced for that transfer, err_cnt_o=0.
6. Saturation: CntWidth=2, five error completions -> err_cnt_o reaches 3 and stays at 3.
